// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL generator state encoding and default sizing
// parameters, reused by the SCL generator and the byte engine.
package i2c_pkg;

  localparam int unsigned DIV_W_DEFAULT       = 16;
  localparam int unsigned STRETCH_MAX_DEFAULT = 1000;

  typedef enum logic [2:0] {
    SCL_IDLE  = 3'd0,
    SCL_LOW1  = 3'd1,
    SCL_LOW2  = 3'd2,
    SCL_SYNC  = 3'd3,
    SCL_HIGH1 = 3'd4,
    SCL_HIGH2 = 3'd5
  } scl_state_e;

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for the sensed SCL bus level.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (flops reset to 1,
//                the idle level of an open-drain bus)
//   d_i        : asynchronous input
//   q_o        : synchronised output
module i2c_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2c_sclgen.sv
// I2C SCL generator: produces a continuous SCL clock split into four
// quarter phases of div_q+1 cycles each, waits for the bus to actually go
// high after release (slave clock stretching) with a timeout, and emits
// timing strobes for the byte engine.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : request continuous SCL generation
//   div        : quarter-period length minus one (latched at period start)
//   scl_in     : sensed SCL bus level (asynchronous)
//   scl_o      : 1 = release SCL, 0 = drive SCL low
//   t_data     : pulse at mid-low (SDA may change)
//   t_sample   : pulse at mid-high (SDA sampled)
//   t_end      : pulse when an SCL period completes
//   busy       : high whenever not idle
//   stretch_to : pulse on stretch timeout
module i2c_sclgen
  import i2c_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned STRETCH_MAX = STRETCH_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             scl_in,
  output logic             scl_o,
  output logic             t_data,
  output logic             t_sample,
  output logic             t_end,
  output logic             busy,
  output logic             stretch_to
);

  localparam int unsigned    ST_W     = $clog2(STRETCH_MAX + 1);
  localparam logic [ST_W-1:0] ST_LIMIT = ST_W'(STRETCH_MAX);

  scl_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ST_W-1:0]  st_q, st_d;
  logic             scl_q, scl_d;
  logic             tdata_q, tdata_d;
  logic             tsample_q, tsample_d;
  logic             tend_q, tend_d;
  logic             busy_q, busy_d;
  logic             sto_q, sto_d;
  logic             scl_sync;

  i2c_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (scl_in),
    .q_o   (scl_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SCL_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      st_q      <= '0;
      scl_q     <= 1'b1;
      tdata_q   <= 1'b0;
      tsample_q <= 1'b0;
      tend_q    <= 1'b0;
      busy_q    <= 1'b0;
      sto_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      st_q      <= st_d;
      scl_q     <= scl_d;
      tdata_q   <= tdata_d;
      tsample_q <= tsample_d;
      tend_q    <= tend_d;
      busy_q    <= busy_d;
      sto_q     <= sto_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    st_d      = st_q;
    scl_d     = scl_q;
    tdata_d   = 1'b0;
    tsample_d = 1'b0;
    tend_d    = 1'b0;
    sto_d     = 1'b0;

    case (state_q)
      SCL_IDLE: begin
        scl_d = 1'b1;
        if (en) begin
          state_d = SCL_LOW1;
          scl_d   = 1'b0;
          div_d   = div;
          cnt_d   = div;
        end
      end
      SCL_LOW1: begin
        if (cnt_q == '0) begin
          state_d = SCL_LOW2;
          cnt_d   = div_q;
          tdata_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      SCL_LOW2: begin
        if (cnt_q == '0) begin
          state_d = SCL_SYNC;
          scl_d   = 1'b1;
          st_d    = '0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      SCL_SYNC: begin
        // A released line seen high wins over a timeout in the same cycle.
        if (scl_sync) begin
          state_d = SCL_HIGH1;
          cnt_d   = div_q;
        end else if (st_q == ST_LIMIT) begin
          state_d = SCL_IDLE;
          scl_d   = 1'b1;
          sto_d   = 1'b1;
        end else begin
          st_d = st_q + ST_W'(1);
        end
      end
      SCL_HIGH1: begin
        if (cnt_q == '0) begin
          state_d   = SCL_HIGH2;
          cnt_d     = div_q;
          tsample_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      SCL_HIGH2: begin
        if (cnt_q == '0) begin
          tend_d = 1'b1;
          if (en) begin
            state_d = SCL_LOW1;
            scl_d   = 1'b0;
            div_d   = div;
            cnt_d   = div;
          end else begin
            state_d = SCL_IDLE;
            scl_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = SCL_IDLE;
        scl_d   = 1'b1;
      end
    endcase

    // busy is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d != SCL_IDLE);
  end

  assign scl_o      = scl_q;
  assign t_data     = tdata_q;
  assign t_sample   = tsample_q;
  assign t_end      = tend_q;
  assign busy       = busy_q;
  assign stretch_to = sto_q;

endmodule

// File: tb/tb_i2c_sclgen.sv
module tb_i2c_sclgen;

  localparam int unsigned DW     = 16;
  localparam int unsigned TO_MAX = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [DW-1:0] div;
  logic          hold;
  logic          scl_in;
  logic          scl_o, t_data, t_sample, t_end, busy, stretch_to;

  logic          en_to;
  logic [7:0]    div_to;
  logic          scl_in_to;
  logic          scl_o_to, t_data_to, t_sample_to, t_end_to, busy_to, stretch_to_to;

  int tests = 0;
  int fails = 0;

  // Per-period stimulus for run_seq: quarter divisor and slave stretch cycles.
  int pd [8];
  int ps [8];

  always #5 clk = ~clk;

  // Open-drain bus: low if either master or slave pulls it down.
  assign scl_in = scl_o & ~hold;

  i2c_sclgen #(.DIV_W(DW), .STRETCH_MAX(1000)) dut (
    .clk(clk), .reset(reset), .en(en), .div(div), .scl_in(scl_in),
    .scl_o(scl_o), .t_data(t_data), .t_sample(t_sample), .t_end(t_end),
    .busy(busy), .stretch_to(stretch_to)
  );

  i2c_sclgen #(.DIV_W(8), .STRETCH_MAX(TO_MAX)) dut_to (
    .clk(clk), .reset(reset), .en(en_to), .div(div_to), .scl_in(scl_in_to),
    .scl_o(scl_o_to), .t_data(t_data_to), .t_sample(t_sample_to), .t_end(t_end_to),
    .busy(busy_to), .stretch_to(stretch_to_to)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a period with divisor d and stretch s lasts 4(d+1)+3+s cycles from
  // the falling edge; SCL is low for 2(d+1), t_data at d+1, t_sample at
  // d+1 into the high phase proper, t_end on the first cycle after the period.
  task automatic run_seq(input string name, input int np);
    int r, l, tsmp;
    logic [5:0] got, want;
    en = 1'b1; div = DW'(pd[0]); hold = 1'b0;
    tick();
    for (int k = 0; k < np; k++) begin
      r    = 2 * (pd[k] + 1);
      tsmp = r + 3 + ps[k] + pd[k] + 1;
      l    = r + 3 + ps[k] + 2 * (pd[k] + 1);
      for (int o = 0; o < l; o++) begin
        got  = {scl_o, t_data, t_sample, t_end, busy, stretch_to};
        want = {(o >= r), (o == pd[k] + 1), (o == tsmp), (o == 0 && k > 0), 1'b1, 1'b0};
        tests++;
        if (got !== want) begin
          fails++;
          $display("FAIL %s period%0d off%0d scl/tdata/tsample/tend/busy/sto got %b want %b",
                   name, k, o, got, want);
        end
        if (o == l - 1) begin
          if (k < np - 1) begin
            en = 1'b1; div = DW'(pd[k + 1]);
          end else begin
            en = 1'b0; div = DW'($urandom);
          end
        end else begin
          en  = 1'($urandom);
          div = DW'($urandom);
        end
        hold = (ps[k] > 0) && (o >= r - 1) && (o < r + ps[k]);
        tick();
      end
    end
    got = {scl_o, t_data, t_sample, t_end, busy, stretch_to};
    tests++;
    if (got !== 6'b100100) begin
      fails++;
      $display("FAIL %s end-cycle got %b want %b", name, got, 6'b100100);
    end
    en = 1'b0; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {scl_o, t_data, t_sample, t_end, busy, stretch_to};
      tests++;
      if (got !== 6'b100000) begin
        fails++;
        $display("FAIL %s idle%0d got %b want %b", name, i, got, 6'b100000);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b1; en = 1'b0; div = '0; hold = 1'b0;
    en_to = 1'b0; div_to = '0; scl_in_to = 1'b0;
    tick(); tick();
    got = {scl_o, t_data, t_sample, t_end, busy, stretch_to};
    tests++;
    if (got !== 6'b100000) begin
      fails++; $display("FAIL reset_state got %b want %b", got, 6'b100000);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = {scl_o, t_data, t_sample, t_end, busy, stretch_to};
      tests++;
      if (got !== 6'b100000) begin
        fails++; $display("FAIL reset_idle_no_en%0d got %b want %b", i, got, 6'b100000);
      end
    end
  endtask

  task automatic test_basic();
    pd[0] = 4; pd[1] = 4; pd[2] = 4; ps[0] = 0; ps[1] = 0; ps[2] = 0;
    run_seq("basic_div4", 3);
  endtask

  task automatic test_div0_single();
    pd[0] = 0; ps[0] = 0;
    run_seq("div0_single", 1);
  endtask

  task automatic test_stretch();
    pd[0] = 4; pd[1] = 4; ps[0] = 50; ps[1] = 0;
    run_seq("stretch50", 2);
  endtask

  task automatic test_div_change();
    pd[0] = 4; pd[1] = 2; ps[0] = 0; ps[1] = 0;
    run_seq("div_change", 2);
  endtask

  task automatic test_random();
    int np;
    for (int n = 0; n < 5; n++) begin
      np = int'($urandom_range(1, 4));
      for (int k = 0; k < np; k++) begin
        pd[k] = int'($urandom_range(0, 6));
        ps[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
      end
      run_seq("random", np);
    end
  endtask

  task automatic test_timeout();
    int d, r, pulses, ends, datas, samples, hit;
    d = int'($urandom_range(0, 5));
    r = 2 * (d + 1);
    en_to = 1'b1; div_to = 8'(d); scl_in_to = 1'b0;
    tick();
    en_to = 1'b0;
    pulses = 0; ends = 0; datas = 0; samples = 0; hit = -1;
    for (int o = 0; o < r + int'(TO_MAX) + 10; o++) begin
      if (stretch_to_to) begin
        pulses++;
        if (hit < 0) hit = o;
      end
      if (t_end_to) ends++;
      if (t_data_to) datas++;
      if (t_sample_to) samples++;
      if (o == r) begin
        tests++;
        if (scl_o_to !== 1'b1) begin
          fails++; $display("FAIL timeout_release scl_o got %b want 1", scl_o_to);
        end
      end
      tick();
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL timeout_pulses got %0d want 1", pulses);
    end
    tests++;
    if (hit < r + int'(TO_MAX) || hit > r + int'(TO_MAX) + 3) begin
      fails++; $display("FAIL timeout_when got %0d want %0d..%0d", hit, r + int'(TO_MAX), r + int'(TO_MAX) + 3);
    end
    tests++;
    if (ends != 0 || samples != 0 || datas != 1) begin
      fails++; $display("FAIL timeout_strobes t_end/t_sample/t_data got %0d/%0d/%0d want 0/0/1", ends, samples, datas);
    end
    tests++;
    if ({scl_o_to, busy_to} !== 2'b10) begin
      fails++; $display("FAIL timeout_idle scl_o/busy got %b want 10", {scl_o_to, busy_to});
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] got;
    int left;
    en = 1'b1; div = DW'(4); hold = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    // 15 cycles after the fall with div=4 is inside HIGH1.
    tests++;
    if ({scl_o, busy} !== 2'b11) begin
      fails++; $display("FAIL midreset_pre scl_o/busy got %b want 11", {scl_o, busy});
    end
    #2 reset = 1'b1;
    #1;
    got = {scl_o, t_data, t_sample, t_end, busy, stretch_to};
    tests++;
    if (got !== 6'b100000) begin
      fails++; $display("FAIL midreset_async got %b want %b", got, 6'b100000);
    end
    tick();
    en = 1'b1;
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({scl_o, busy} !== 2'b10) begin
      fails++; $display("FAIL midreset_release scl_o/busy got %b want 10", {scl_o, busy});
    end
    tick();
    tests++;
    if ({scl_o, busy} !== 2'b01) begin
      fails++; $display("FAIL midreset_restart scl_o/busy got %b want 01", {scl_o, busy});
    end
    en = 1'b0;
    left = 100;
    while (busy && left > 0) begin
      tick();
      left--;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL midreset_drain busy got %b want 0", busy);
    end
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_div0_single();
    test_stretch();
    test_div_change();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_sclgen.md
I2C_SCLGEN -- requirements
Module: i2c_sclgen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the quarter-period divisor input.
REQ-002 SHALL have parameter STRETCH_MAX, default 1000: maximum clk cycles SCL may be held low by a slave before timeout.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1: request continuous SCL generation.
REQ-006 SHALL have port div, input, DIV_W: quarter-period length minus one, in clk cycles.
REQ-007 SHALL have port scl_in, input, 1: sensed SCL bus level, asynchronous.
REQ-008 SHALL have port scl_o, output, 1: 1 = release SCL, 0 = drive SCL low.
REQ-009 SHALL have port t_data, output, 1: one-cycle pulse at mid-low, where SDA may change.
REQ-010 SHALL have port t_sample, output, 1: one-cycle pulse at mid-high, where SDA is sampled.
REQ-011 SHALL have port t_end, output, 1: one-cycle pulse when an SCL period completes.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port stretch_to, output, 1: one-cycle pulse on stretch timeout.

Function
REQ-014 SHALL implement states IDLE, LOW1, LOW2, SYNC, HIGH1 and HIGH2; all outputs SHALL be registered.
REQ-015 In IDLE with en=1, the next cycle SHALL be LOW1 with scl_o=0, div latched into div_q, and down-counter cnt=div.
REQ-016 div_q SHALL be re-latched only on entry to LOW1; div changes mid-period take effect from the next period.
REQ-017 Each of LOW1, LOW2, HIGH1 and HIGH2 SHALL last exactly div_q+1 cycles; cnt decrements each cycle and the state advances when cnt==0, reloading cnt=div_q.
REQ-018 div=0 SHALL be legal and give 1-cycle quarter phases.
REQ-019 LOW1->LOW2 SHALL assert t_data in the first LOW2 cycle.
REQ-020 LOW2 end SHALL enter SYNC with scl_o=1 and the stretch counter cleared.
REQ-021 SYNC SHALL advance to HIGH1 on the first cycle the synchronised scl_in is 1; with no slave stretch, SYNC SHALL last exactly 3 cycles.
REQ-022 If the stretch counter reaches STRETCH_MAX in SYNC, the block SHALL pulse stretch_to and go to IDLE with scl_o=1; no t_end SHALL be asserted.
REQ-023 HIGH1->HIGH2 SHALL assert t_sample in the first HIGH2 cycle.
REQ-024 HIGH2 end SHALL pulse t_end, then go to LOW1 (scl_o=0, relatch div) if en=1, else to IDLE (scl_o=1).
REQ-025 Deasserting en mid-period SHALL NOT truncate the period; the block stops only at HIGH2 end.
REQ-026 The SCL period without stretch SHALL be 4(div_q+1)+3 cycles.

Reset
REQ-027 Reset SHALL immediately force IDLE, scl_o=1, t_data=t_sample=t_end=stretch_to=busy=0, cnt=0, div_q=0, stretch counter=0, and synchroniser flops=1, including mid-period.
REQ-028 Operation after reset release SHALL start only on a cycle where en=1 is sampled in IDLE.

Structure
REQ-029 State encodings and the default DIV_W/STRETCH_MAX SHALL reside in the shared package i2c_pkg, reused by the byte engine.
REQ-030 scl_in SHALL be synchronised by sub-module i2c_sync2 (two flops, reset value 1); the stretch counter width SHALL be $clog2(STRETCH_MAX+1).

Verification
REQ-031 div=4, en held 1, scl_in=scl_o -> scl_o low 10 cycles, high 13 cycles (3 SYNC + 10 HIGH), period 23; t_data 5 cycles after the fall; t_sample 8 cycles after the release.
REQ-032 div=0, en pulsed 1 cycle -> exactly one period of 7 cycles, one t_end, then IDLE with busy=0.
REQ-033 div=4, slave holds scl_in low 50 extra cycles -> SYNC lasts 53 cycles, no stretch_to, normal HIGH phase follows.
REQ-034 STRETCH_MAX=20, scl_in stuck 0 -> stretch_to pulses once, IDLE, scl_o=1, no t_end.
REQ-035 div changed from 4 to 2 during LOW2 -> current period 23 cycles, next period 15 cycles.
REQ-036 reset asserted during HIGH1 -> scl_o=1 and busy=0 immediately; en=1 after release -> scl_o falls one cycle later.
